// File: rtl/log_pkg.sv
// Shared types and lane geometry for the log spawner and its per-slot lifetime logic.
package log_pkg;
  localparam int NUM_LOGS_DEF = 100;
  localparam int LANES_DEF    = 5;
  localparam int LANE_Y0_DEF  = 64;
  localparam int LANE_H_DEF   = 32;
  localparam int X_RIGHT_DEF  = 480;
  localparam int OFS_W        = 9;

  typedef logic [3:0]       lane_t;
  typedef logic [OFS_W-1:0] ofs_t;

  typedef enum logic [1:0] {IDLE, SCAN, ALLOC, DROP} spawn_state_t;

  // Y is formed at 10 bits and truncated; parameters keep it within 9 bits.
  function automatic ofs_t lane_y(lane_t lane, int y0, int h);
    logic [9:0] y;
    y = 10'(y0) + 10'(lane) * 10'(h);
    return y[OFS_W-1:0];
  endfunction

  function automatic ofs_t lane_x(lane_t lane, int xr);
    return lane[0] ? ofs_t'(xr) : '0;
  endfunction
endpackage

// File: rtl/log_slot_lifetime.sv
// One log slot: enable flop plus an 8-bit tick down-counter that retires the slot.
module log_slot_lifetime #(
  parameter int LIFETIME = 60
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic load,
  input  logic tick,
  output logic enable
);
  logic [7:0] life;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      life   <= '0;
      enable <= 1'b0;
    end else if (load) begin
      life   <= 8'(LIFETIME);
      enable <= 1'b1;
    end else if (tick && enable) begin
      life <= life - 8'd1;
      if (life == 8'd1) enable <= 1'b0;
    end
  end
endmodule

// File: rtl/log_spawner.sv
// Log spawner: tick-driven request, linear free-slot scan, lane/offset assignment, slot retirement.
// Optional per-lane spacing is built when LOG_SPAWN_LANE_GAP_EN is defined.
module log_spawner
  import log_pkg::*;
#(
  parameter int NUM_LOGS     = NUM_LOGS_DEF,
  parameter int LANES        = LANES_DEF,
  parameter int LANE_Y0      = LANE_Y0_DEF,
  parameter int LANE_H       = LANE_H_DEF,
  parameter int X_RIGHT      = X_RIGHT_DEF,
  parameter int SPAWN_PERIOD = 4,
`ifdef LOG_SPAWN_LANE_GAP_EN
  parameter int MIN_GAP      = 3,
`endif
  parameter int LIFETIME     = 60
) (
  input  logic                         CLK,
  input  logic                         RESETn,
  input  logic                         timer_done,
  input  logic [3:0]                   random_0_15,
  output logic [NUM_LOGS-1:0]          enable,
  output logic [NUM_LOGS-1:0][OFS_W-1:0] start_offsetY,
  output logic [NUM_LOGS-1:0][OFS_W-1:0] start_offsetX,
  output logic [7:0]                   drop_count,
  output logic                         busy
);
  localparam int IDX_W = (NUM_LOGS > 1) ? $clog2(NUM_LOGS) : 1;

  spawn_state_t      state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  lane_t             lane, lane_n, lane_rnd;
  logic [7:0]        drop_n;
  logic [15:0]       spawn_cnt;
  logic              pending, spawn_req, leave_idle, scan_en;
  logic [NUM_LOGS-1:0] load;

  function automatic lane_t next_lane(lane_t l);
    return (l == lane_t'(LANES-1)) ? '0 : l + lane_t'(1);
  endfunction

  assign lane_rnd  = lane_t'({28'd0, random_0_15} % LANES);
  assign spawn_req = timer_done && (spawn_cnt == 16'(SPAWN_PERIOD-1));

  always_ff @(posedge CLK) begin
    if (!RESETn)         spawn_cnt <= '0;
    else if (timer_done) spawn_cnt <= spawn_req ? '0 : spawn_cnt + 16'd1;
  end

  // One-deep request latch; a request arriving while one is outstanding is lost.
  always_ff @(posedge CLK) begin
    if (!RESETn) pending <= 1'b0;
    else         pending <= (pending && !leave_idle) || (spawn_req && !pending);
  end

  always_comb begin
    scan_en = 1'b0;
    load    = '0;
    for (int i = 0; i < NUM_LOGS; i++) begin
      if (idx == IDX_W'(i)) begin
        scan_en = enable[i];
        load[i] = (state == ALLOC);
      end
    end
  end

`ifdef LOG_SPAWN_LANE_GAP_EN
  logic [LANES-1:0][7:0] gap_cnt;
  logic                  picking, picking_n, free_cur, free_rnd;
  lane_t                 tries, tries_n;

  always_comb begin
    free_cur = 1'b0;
    free_rnd = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (lane == lane_t'(l))     free_cur = (gap_cnt[l] == 8'd0);
      if (lane_rnd == lane_t'(l)) free_rnd = (gap_cnt[l] == 8'd0);
    end
  end

  // Allocation reload beats a coincident tick so the full gap is always honoured.
  always_ff @(posedge CLK) begin
    for (int l = 0; l < LANES; l++) begin
      if (!RESETn)                                   gap_cnt[l] <= '0;
      else if (state == ALLOC && lane == lane_t'(l)) gap_cnt[l] <= 8'(MIN_GAP);
      else if (timer_done && gap_cnt[l] != 8'd0)     gap_cnt[l] <= gap_cnt[l] - 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      picking <= 1'b0;
      tries   <= '0;
    end else begin
      picking <= picking_n;
      tries   <= tries_n;
    end
  end
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    lane_n  = lane;
    drop_n  = drop_count;
`ifdef LOG_SPAWN_LANE_GAP_EN
    picking_n = picking;
    tries_n   = tries;
`endif
    case (state)
      IDLE: begin
`ifdef LOG_SPAWN_LANE_GAP_EN
        // First candidate is checked in the request cycle; later lanes take one cycle each.
        if (picking) begin
          if (free_cur) begin
            state_n   = SCAN;
            idx_n     = '0;
            picking_n = 1'b0;
          end else if (tries == lane_t'(LANES-1)) begin
            state_n   = DROP;
            picking_n = 1'b0;
          end else begin
            lane_n  = next_lane(lane);
            tries_n = tries + lane_t'(1);
          end
        end else if (pending) begin
          if (free_rnd) begin
            lane_n  = lane_rnd;
            idx_n   = '0;
            state_n = SCAN;
          end else if (LANES == 1) begin
            state_n = DROP;
          end else begin
            lane_n    = next_lane(lane_rnd);
            tries_n   = lane_t'(1);
            picking_n = 1'b1;
          end
        end
`else
        if (pending) begin
          lane_n  = lane_rnd;
          idx_n   = '0;
          state_n = SCAN;
        end
`endif
      end
      SCAN: begin
        if (!scan_en)                          state_n = ALLOC;
        else if (idx == IDX_W'(NUM_LOGS-1))    state_n = DROP;
        else                                   idx_n   = idx + 1'b1;
      end
      ALLOC: state_n = IDLE;
      DROP: begin
        state_n = IDLE;
        if (drop_count != 8'hFF) drop_n = drop_count + 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign leave_idle = (state == IDLE) && (state_n != IDLE);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state      <= IDLE;
      idx        <= '0;
      lane       <= '0;
      drop_count <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      lane       <= lane_n;
      drop_count <= drop_n;
      busy       <= (state_n != IDLE);
    end
  end

  // Offsets are only written on allocation, so a retired slot keeps its last position.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      start_offsetY <= '0;
      start_offsetX <= '0;
    end else begin
      for (int i = 0; i < NUM_LOGS; i++) begin
        if (load[i]) begin
          start_offsetY[i] <= lane_y(lane, LANE_Y0, LANE_H);
          start_offsetX[i] <= lane_x(lane, X_RIGHT);
        end
      end
    end
  end

  log_slot_lifetime #(.LIFETIME(LIFETIME)) u_slot [NUM_LOGS-1:0] (
    .CLK    (CLK),
    .RESETn (RESETn),
    .load   (load),
    .tick   ({NUM_LOGS{timer_done}}),
    .enable (enable)
  );
endmodule

// File: tb/tb_log_spawner.sv
// Directed bench: two spawner instances (short-lifetime 8-slot, long-lifetime 4-slot).
module tb_log_spawner;
  logic clk = 1'b0;
  logic rst_n;
  logic td_a, td_b;
  logic [3:0] rnd_a, rnd_b;

  logic [7:0]      en_a;
  logic [7:0][8:0] y_a, x_a;
  logic [7:0]      drop_a;
  logic            busy_a;

  logic [3:0]      en_b;
  logic [3:0][8:0] y_b, x_b;
  logic [7:0]      drop_b;
  logic            busy_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  log_spawner #(.NUM_LOGS(8), .SPAWN_PERIOD(4), .LIFETIME(2)) u_a (
    .CLK(clk), .RESETn(rst_n), .timer_done(td_a), .random_0_15(rnd_a),
    .enable(en_a), .start_offsetY(y_a), .start_offsetX(x_a),
    .drop_count(drop_a), .busy(busy_a)
  );

  log_spawner #(.NUM_LOGS(4), .SPAWN_PERIOD(1), .LIFETIME(255)) u_b (
    .CLK(clk), .RESETn(rst_n), .timer_done(td_b), .random_0_15(rnd_b),
    .enable(en_b), .start_offsetY(y_b), .start_offsetX(x_b),
    .drop_count(drop_b), .busy(busy_b)
  );

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_a;
    @(negedge clk); td_a = 1'b1;
    @(negedge clk); td_a = 1'b0;
  endtask

  task automatic tick_b;
    @(negedge clk); td_b = 1'b1;
    @(negedge clk); td_b = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; td_a = 1'b0; td_b = 1'b0; rnd_a = '0; rnd_b = '0;
    wait_cyc(3);
    tests++; if (en_a !== 8'h00) begin fails++; $display("FAIL reset_en_a got %h want 00", en_a); end
    tests++; if (busy_a !== 1'b0 || drop_a !== 8'd0) begin fails++; $display("FAIL reset_a busy %b drop %0d want 0 0", busy_a, drop_a); end
    tests++; if (en_b !== 4'h0 || busy_b !== 1'b0 || drop_b !== 8'd0) begin fails++; $display("FAIL reset_b en %h busy %b drop %0d want 0 0 0", en_b, busy_b, drop_b); end
    rst_n = 1'b1;
    wait_cyc(2);
  endtask

  // Fourth tick requests; lane 7 mod 5 = 2 -> Y 128, X 0; enable appears 3 cycles after the tick.
  task automatic test_spawn_even;
    rnd_a = 4'd7;
    for (int i = 0; i < 3; i++) begin tick_a(); wait_cyc(4); end
    tests++; if (en_a !== 8'h00) begin fails++; $display("FAIL early_spawn en %h want 00", en_a); end
    tick_a();
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL busy_at_tick got %b want 0", busy_a); end
    wait_cyc(1);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL busy_scan got %b want 1", busy_a); end
    wait_cyc(1);
    tests++; if (en_a[0] !== 1'b0) begin fails++; $display("FAIL en_latency_t2 got %b want 0", en_a[0]); end
    wait_cyc(1);
    tests++; if (en_a !== 8'h01) begin fails++; $display("FAIL en_latency_t3 got %h want 01", en_a); end
    tests++; if (y_a[0] !== 9'd128 || x_a[0] !== 9'd0) begin fails++; $display("FAIL even_lane_ofs y %0d x %0d want 128 0", y_a[0], x_a[0]); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL busy_after_alloc got %b want 0", busy_a); end
  endtask

  task automatic test_lifetime;
    wait_cyc(3);
    tick_a();
    tests++; if (en_a[0] !== 1'b1) begin fails++; $display("FAIL life_tick1 got %b want 1", en_a[0]); end
    wait_cyc(3);
    tick_a();
    tests++; if (en_a[0] !== 1'b0) begin fails++; $display("FAIL life_tick2 got %b want 0", en_a[0]); end
    tests++; if (y_a[0] !== 9'd128) begin fails++; $display("FAIL retired_ofs_hold y %0d want 128", y_a[0]); end
  endtask

  // Lane 8 mod 5 = 3 (odd): Y 160, X 480; the retired slot 0 is reused.
  task automatic test_spawn_odd;
    rnd_a = 4'd8;
    wait_cyc(3);
    tick_a(); wait_cyc(3);
    tick_a(); wait_cyc(5);
    tests++; if (en_a !== 8'h01) begin fails++; $display("FAIL reuse_slot0 en %h want 01", en_a); end
    tests++; if (y_a[0] !== 9'd160 || x_a[0] !== 9'd480) begin fails++; $display("FAIL odd_lane_ofs y %0d x %0d want 160 480", y_a[0], x_a[0]); end
  endtask

  // Two back-to-back spawns with the same random value.
  task automatic test_back_to_back;
    logic [8:0] ey, ex;
`ifdef LOG_SPAWN_LANE_GAP_EN
    ey = 9'd160; ex = 9'd480;
`else
    ey = 9'd128; ex = 9'd0;
`endif
    rnd_b = 4'd7;
    tick_b(); wait_cyc(12);
    tests++; if (en_b !== 4'b0001 || y_b[0] !== 9'd128 || x_b[0] !== 9'd0) begin fails++; $display("FAIL b2b_first en %b y %0d x %0d want 0001 128 0", en_b, y_b[0], x_b[0]); end
    tick_b(); wait_cyc(12);
    tests++; if (en_b !== 4'b0011 || y_b[1] !== ey || x_b[1] !== ex) begin fails++; $display("FAIL b2b_second en %b y %0d x %0d want 0011 %0d %0d", en_b, y_b[1], x_b[1], ey, ex); end
  endtask

  task automatic test_pool_full;
    for (int i = 0; i < 2; i++) begin tick_b(); wait_cyc(12); end
    tests++; if (en_b !== 4'b1111 || drop_b !== 8'd0) begin fails++; $display("FAIL pool_filled en %b drop %0d want 1111 0", en_b, drop_b); end
    tick_b(); wait_cyc(12);
    tests++; if (drop_b !== 8'd1) begin fails++; $display("FAIL first_drop got %0d want 1", drop_b); end
    for (int i = 6; i <= 200; i++) begin tick_b(); wait_cyc(12); end
    tests++; if (drop_b !== 8'd196) begin fails++; $display("FAIL drops_200 got %0d want 196", drop_b); end
    for (int i = 201; i <= 305; i++) begin tick_b(); wait_cyc(12); end
    tests++; if (drop_b !== 8'd255) begin fails++; $display("FAIL drop_saturate got %0d want 255", drop_b); end
    tests++; if (en_b !== 4'b1111) begin fails++; $display("FAIL pool_refilled en %b want 1111", en_b); end
  endtask

  task automatic test_reset_mid_scan;
    tick_b(); wait_cyc(1);
    tests++; if (busy_b !== 1'b1) begin fails++; $display("FAIL mid_scan_busy got %b want 1", busy_b); end
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    tests++; if (en_b !== 4'h0 || busy_b !== 1'b0 || drop_b !== 8'd0) begin fails++; $display("FAIL mid_scan_reset en %b busy %b drop %0d want 0 0 0", en_b, busy_b, drop_b); end
    wait_cyc(3);
    tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL idle_after_reset busy %b want 0", busy_b); end
    tick_b(); wait_cyc(8);
    tests++; if (en_b !== 4'b0001) begin fails++; $display("FAIL spawn_after_reset en %b want 0001", en_b); end
  endtask

  initial begin
    test_reset();
    test_spawn_even();
    test_lifetime();
    test_spawn_odd();
    test_back_to_back();
    test_pool_full();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
